// File: rtl/data_mem_pipe_pkg.sv
// Shared definitions for the pipelined data memory: RV32I load/store func3
// codes, wait-counter width and the simulation fill pattern.
package data_mem_pipe_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  localparam int WAIT_CNT_W = 4;

  // Fill word for word index idx: byte b of memory reads 8'h80 | b[7:0],
  // and b[7:0] = {idx[5:0], lane}, so only idx[4:0] survives the OR.
  function automatic logic [31:0] init_word(input logic [4:0] idx_lo);
    init_word = {1'b1, idx_lo, 2'd3, 1'b1, idx_lo, 2'd2,
                 1'b1, idx_lo, 2'd1, 1'b1, idx_lo, 2'd0};
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatter: store byte enables and lane-aligned data, load
// extraction/extension, and alignment/illegal-func3 detection.
module mem_lane_fmt
  import data_mem_pipe_pkg::*;
(
  input  logic        i_we,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_fault
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = 8'(i_raw >> {i_addr, 3'b000});
  assign w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];

  always_comb begin
    o_be    = '0;
    o_wdata = '0;
    o_rdata = '0;
    o_fault = 1'b0;
    if (i_we) begin
      case (i_func3)
        F3_SB: begin
          o_be    = 4'b0001 << i_addr;
          o_wdata = {4{i_wdata[7:0]}};
        end
        F3_SH: begin
          o_fault = i_addr[0];
          o_be    = i_addr[1] ? 4'b1100 : 4'b0011;
          o_wdata = {2{i_wdata[15:0]}};
        end
        F3_SW: begin
          o_fault = (i_addr != 2'b00);
          o_be    = 4'b1111;
          o_wdata = i_wdata;
        end
        default: o_fault = 1'b1;
      endcase
    end else begin
      case (i_func3)
        F3_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
        F3_LBU: o_rdata = {24'd0, w_byte};
        F3_LH: begin
          o_fault = i_addr[0];
          o_rdata = {{16{w_half[15]}}, w_half};
        end
        F3_LHU: begin
          o_fault = i_addr[0];
          o_rdata = {16'd0, w_half};
        end
        F3_LW: begin
          o_fault = (i_addr != 2'b00);
          o_rdata = i_raw;
        end
        default: o_fault = 1'b1;
      endcase
    end
    // A faulted access must neither write nor return data.
    if (o_fault) begin
      o_be    = '0;
      o_rdata = '0;
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Data memory with valid/ready request/response handshake, configurable
// wait states, fault detection and a saturating fault counter.
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int WAIT_CYCLES  = 1,
  parameter bit INIT_PATTERN = 1'b1
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] err_cnt,
  output logic [1:0]  dbg_state
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t                r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                  r_we;
  logic [31:0]           r_addr, r_wdata;
  logic [2:0]            r_func3;
  logic [31:0]           r_rsp_rdata;
  logic                  r_rsp_err;
  logic [15:0]           r_err_cnt;
  logic [31:0]           r_mem [DEPTH_WORDS];

  logic             w_accept, w_direct, w_commit, w_wr_en;
  logic             w_c_we;
  logic [31:0]      w_c_addr, w_c_wdata;
  logic [2:0]       w_c_func3;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_mask, w_raw, w_wdata_lane, w_ld_data;
  logic [3:0]       w_be;
  logic             w_fmt_fault, w_range_fault, w_fault;

  // Handshake: a request transfers on an edge where req_valid && req_ready,
  // a response on an edge where rsp_valid && rsp_ready; a new request may
  // transfer on the same edge that retires the previous response.
  assign req_ready = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign w_accept  = req_valid && req_ready;

  // With no wait states the access commits on its own accept edge, straight
  // from the request inputs; otherwise from the captured request.
  assign w_direct  = w_accept && (WAIT_CYCLES == 0);
  assign w_commit  = w_direct || ((r_state == WAIT) && (r_cnt == '0));
  assign w_c_we    = w_direct ? req_we    : r_we;
  assign w_c_addr  = w_direct ? req_addr  : r_addr;
  assign w_c_wdata = w_direct ? req_wdata : r_wdata;
  assign w_c_func3 = w_direct ? req_func3 : r_func3;

  assign w_idx         = w_c_addr[IDX_W+1:2];
  assign w_range_fault = (w_c_addr[31:2] >= 30'(DEPTH_WORDS));

  // Words are stored XOR'd with the fill pattern, so a zero-initialised
  // array reads back as the pattern without any reset or init sweep.
  assign w_mask = INIT_PATTERN ? init_word(5'(w_idx)) : 32'd0;
  assign w_raw  = r_mem[w_idx] ^ w_mask;

  mem_lane_fmt u_fmt (
    .i_we    (w_c_we),
    .i_func3 (w_c_func3),
    .i_addr  (w_c_addr[1:0]),
    .i_wdata (w_c_wdata),
    .i_raw   (w_raw),
    .o_be    (w_be),
    .o_wdata (w_wdata_lane),
    .o_rdata (w_ld_data),
    .o_fault (w_fmt_fault)
  );

  assign w_fault = w_fmt_fault || w_range_fault;
  assign w_wr_en = w_commit && w_c_we && !w_fault;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: w_state_nxt = IDLE;
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) begin
      if (WAIT_CYCLES == 0) begin
        w_state_nxt = RESP;
      end else begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = WAIT_CNT_W'(WAIT_CYCLES - 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_func3     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_func3 <= req_func3;
      end
      if (w_commit) begin
        r_rsp_err   <= w_fault;
        r_rsp_rdata <= (w_c_we || w_fault) ? 32'd0 : w_ld_data;
        if (w_fault && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8] ^ w_mask[8*b +: 8];
      end
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule
